// File: rtl/pll_ctrl_pkg.sv
// Shared types, default widths and saturating helpers for the PLL PI loop controller.
// Contents:
//   *_DEF         default widths used by the interface and top-level parameters
//   wide_t        wide signed type used for all intermediate datapath arithmetic
//   lock_state_e  lock-detector states
//   clamp/sat_add saturating arithmetic on wide_t
package pll_ctrl_pkg;

    localparam int unsigned ERR_W_DEF  = 10;
    localparam int unsigned CODE_W_DEF = 12;
    localparam int unsigned FRAC_W_DEF = 4;

    // Wide enough that no gain product or P+I sum can overflow before it is clamped.
    localparam int unsigned WIDE_W = 48;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } lock_state_e;

    // Limit x to the range [lo, hi].
    function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
        wide_t r;
        r = x;
        if (x < lo) begin
            r = lo;
        end else if (x > hi) begin
            r = hi;
        end
        return r;
    endfunction

    // Add two values and limit the result symmetrically to +/-lim.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input wide_t lim);
        return clamp(a + b, -lim, lim);
    endfunction

endpackage

// File: rtl/pll_dig_pi_ctrl_if.sv
// Error-sample / control-code bundle between the PD sampler, the PI controller and the DAC.
// Signals:
//   err, err_valid                    error sample from the phase-detector sampler
//   ctrl_code, ctrl_valid             control code to the ring-oscillator supply DAC
//   sat_hi, sat_lo, locked            status flags
// Modports: master = sampler/DAC side, slave = controller.
interface pll_dig_pi_ctrl_if
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned ERR_W  = ERR_W_DEF,
    parameter int unsigned CODE_W = CODE_W_DEF
);
    logic signed [ERR_W-1:0]  err;
    logic                     err_valid;
    logic        [CODE_W-1:0] ctrl_code;
    logic                     ctrl_valid;
    logic                     sat_hi;
    logic                     sat_lo;
    logic                     locked;

    modport master (
        output err, err_valid,
        input  ctrl_code, ctrl_valid, sat_hi, sat_lo, locked
    );

    modport slave (
        input  err, err_valid,
        output ctrl_code, ctrl_valid, sat_hi, sat_lo, locked
    );

endinterface

// File: rtl/pll_lock_fsm.sv
// Lock detector: counts consecutive in-tolerance error samples and holds lock
// inside a wider hysteresis band.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   err_mag      saturated |err| of the current sample
//   err_valid    sample qualifier; the FSM only advances on valid samples
//   locked       registered lock status
module pll_lock_fsm
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned MAG_W    = ERR_W_DEF - 1,
    parameter int unsigned LOCK_TOL = 4,
    parameter int unsigned LOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] err_mag,
    input  logic             err_valid,
    output logic             locked
);

    localparam int unsigned     CNT_W    = $clog2(LOCK_CNT + 1);
    localparam logic [MAG_W-1:0] TOL_IN  = MAG_W'(LOCK_TOL);
    localparam logic [MAG_W-1:0] TOL_OUT = MAG_W'(2 * LOCK_TOL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lock_state_e      state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             locked_d, locked_q;
    logic             in_tol;
    logic             out_band;

    // State, counter and lock flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACQUIRE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    // Next-state and counter logic; lock is dropped only outside twice the acquire tolerance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_tol   = (err_mag <= TOL_IN);
        out_band = (err_mag > TOL_OUT);

        if (err_valid) begin
            case (state_q)
                ACQUIRE: begin
                    if (in_tol) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_LAST) ? LOCKED : TRACK;
                    end
                end
                TRACK: begin
                    if (in_tol) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_LAST) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                LOCKED: begin
                    if (out_band) begin
                        cnt_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ACQUIRE;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign locked = locked_q;

endmodule

// File: rtl/pll_dig_pi_ctrl.sv
// Fixed-point PI loop controller for the ring-oscillator PLL, clocked by the reference clock.
// Two-stage pipeline: stage 1 registers the P term and updates the integrator (with
// anti-windup against the current saturation flags); stage 2 forms the output code,
// clamps it to the DAC range and flags saturation.
// Ports:
//   clkin    reference clock
//   rst_n    asynchronous active-low reset
//   bus      slave side of pll_dig_pi_ctrl_if (err/err_valid in; ctrl_code, ctrl_valid,
//            sat_hi, sat_lo, locked out)
module pll_dig_pi_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned ERR_W     = ERR_W_DEF,
    parameter int unsigned CODE_W    = CODE_W_DEF,
    parameter int unsigned FRAC_W    = FRAC_W_DEF,
    parameter int unsigned KP        = 16,
    parameter int unsigned KI        = 2,
    parameter int unsigned INIT_CODE = 2048,
    parameter int unsigned LOCK_TOL  = 4,
    parameter int unsigned LOCK_CNT  = 8
) (
    input  logic                clkin,
    input  logic                rst_n,
    pll_dig_pi_ctrl_if.slave    bus
);

    localparam int unsigned INT_W = CODE_W + FRAC_W + 2;
    // Holds KP*err for any KP below 2^16.
    localparam int unsigned P_W   = ERR_W + 17;
    localparam int unsigned MAG_W = ERR_W - 1;

    localparam wide_t INT_LIM  = (wide_t'(1) <<< (CODE_W + FRAC_W)) - wide_t'(1);
    localparam wide_t CODE_MAX = (wide_t'(1) <<< CODE_W) - wide_t'(1);
    localparam wide_t KP_W     = wide_t'(KP);
    localparam wide_t KI_W     = wide_t'(KI);
    localparam wide_t INIT_W   = wide_t'(INIT_CODE);
    localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] INIT_Q = CODE_W'(INIT_CODE);

    logic signed [P_W-1:0]   p_d, p_q;
    logic signed [INT_W-1:0] integ_d, integ_q;
    logic                    v1_d, v1_q;
    logic [CODE_W-1:0]       code_d, code_q;
    logic                    vld_d, vld_q;
    logic                    sat_hi_d, sat_hi_q;
    logic                    sat_lo_d, sat_lo_q;

    wide_t                   err_w;
    wide_t                   raw;
    logic                    hold;
    logic [MAG_W-1:0]        err_mag;

    // Pipeline and output registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= '0;
            integ_q  <= '0;
            v1_q     <= 1'b0;
            code_q   <= INIT_Q;
            vld_q    <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            p_q      <= p_d;
            integ_q  <= integ_d;
            v1_q     <= v1_d;
            code_q   <= code_d;
            vld_q    <= vld_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
        end
    end

    // Stage 1: P term and anti-windup integrator; stage 2: sum, floor-shift and clamp.
    always_comb begin
        p_d      = p_q;
        integ_d  = integ_q;
        v1_d     = bus.err_valid;
        code_d   = code_q;
        vld_d    = v1_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;

        err_w = wide_t'(bus.err);
        // Freeze the integrator while the output is pinned and the error pushes further out.
        hold  = (sat_hi_q && (err_w > wide_t'(0))) || (sat_lo_q && (err_w < wide_t'(0)));

        if (bus.err_valid) begin
            p_d = P_W'(err_w * KP_W);
            if (!hold) begin
                integ_d = INT_W'(sat_add(wide_t'(integ_q), err_w * KI_W, INT_LIM));
            end
        end

        raw = INIT_W + ((wide_t'(p_q) + wide_t'(integ_q)) >>> FRAC_W);

        if (v1_q) begin
            code_d   = CODE_W'(clamp(raw, wide_t'(0), CODE_MAX));
            sat_hi_d = (raw > CODE_MAX);
            sat_lo_d = (raw < wide_t'(0));
        end
    end

    // Saturating |err| so the most negative code does not wrap to zero.
    always_comb begin
        err_mag = '0;
        if ($unsigned(bus.err) == ERR_MIN) begin
            err_mag = '1;
        end else if (bus.err[ERR_W-1]) begin
            err_mag = MAG_W'(-bus.err);
        end else begin
            err_mag = MAG_W'(bus.err);
        end
    end

    pll_lock_fsm #(
        .MAG_W    (MAG_W),
        .LOCK_TOL (LOCK_TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_fsm (
        .clk       (clkin),
        .rst_n     (rst_n),
        .err_mag   (err_mag),
        .err_valid (bus.err_valid),
        .locked    (bus.locked)
    );

    assign bus.ctrl_code  = code_q;
    assign bus.ctrl_valid = vld_q;
    assign bus.sat_hi     = sat_hi_q;
    assign bus.sat_lo     = sat_lo_q;

endmodule

// File: tb/tb_pll_dig_pi_ctrl.sv
// Testbench for pll_dig_pi_ctrl: directed error sequences, expected outputs queued at issue
// and compared by a monitor whenever ctrl_valid is seen.
`timescale 1ns/1ps
module tb_pll_dig_pi_ctrl;

    localparam longint CODE_MAX = 4095;
    localparam longint INIT     = 2048;
    localparam longint ILIM     = 65535;

    typedef struct {
        longint code;
        longint hi;
        longint lo;
        longint due;
    } exp_t;

    logic clkin = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t sb[$];

    // Reference model state.
    longint m_integ = 0;
    bit vis_hi = 0, vis_lo = 0;
    bit p1_v = 0, p1_hi = 0, p1_lo = 0;
    bit p2_v = 0, p2_hi = 0, p2_lo = 0;

    pll_dig_pi_ctrl_if #(.ERR_W(10), .CODE_W(12)) bus ();

    pll_dig_pi_ctrl dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_integ = 0;
        vis_hi = 0; vis_lo = 0;
        p1_v = 0; p1_hi = 0; p1_lo = 0;
        p2_v = 0; p2_hi = 0; p2_lo = 0;
    endtask

    // Called once per cycle; a result issued at cycle c is visible to the anti-windup at c+2.
    task automatic model_step(input bit v, input int e);
        longint p, raw;
        exp_t x;
        if (p2_v) begin
            vis_hi = p2_hi;
            vis_lo = p2_lo;
        end
        p2_v = p1_v; p2_hi = p1_hi; p2_lo = p1_lo;
        p1_v = 0;
        if (v) begin
            p = 16 * e;
            if (!((vis_hi && e > 0) || (vis_lo && e < 0))) begin
                m_integ = m_integ + 2 * e;
                if (m_integ > ILIM) m_integ = ILIM;
                if (m_integ < -ILIM) m_integ = -ILIM;
            end
            raw = INIT + ((p + m_integ) >>> 4);
            x.hi   = (raw > CODE_MAX) ? 1 : 0;
            x.lo   = (raw < 0) ? 1 : 0;
            x.code = (raw > CODE_MAX) ? CODE_MAX : ((raw < 0) ? 0 : raw);
            x.due  = cyc + 2;
            sb.push_back(x);
            p1_v = 1; p1_hi = x.hi[0]; p1_lo = x.lo[0];
        end
    endtask

    task automatic cycle(input bit v, input int e);
        @(posedge clkin);
        #1;
        bus.err_valid = v;
        bus.err       = 10'(e);
        model_step(v, e);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        bus.err_valid = 1'b0;
        bus.err = '0;
        model_clear();
        repeat (n) @(posedge clkin);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every ctrl_valid pulse must match the oldest expected entry.
    always @(negedge clkin) begin
        if (bus.ctrl_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ctrl_valid actual=1 required=0 code=%0d (t=%0t)",
                         bus.ctrl_code, $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("ctrl_code", longint'(bus.ctrl_code), x.code);
                check("sat_hi", longint'(bus.sat_hi), x.hi);
                check("sat_lo", longint'(bus.sat_lo), x.lo);
                check("latency_cycle", longint'(cyc), x.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_seq[8];
        int sparse[6];
        lock_seq = '{0, 1, -1, 4, -4, 2, 3, -2};
        sparse   = '{8, -8, 100, -100, 0, 37};
        bus.err = '0;
        bus.err_valid = 1'b0;

        // 1: reset values
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        check("rst_code", longint'(bus.ctrl_code), 2048);
        check("rst_ctrl_valid", longint'(bus.ctrl_valid), 0);
        check("rst_sat_hi", longint'(bus.sat_hi), 0);
        check("rst_sat_lo", longint'(bus.sat_lo), 0);
        check("rst_locked", longint'(bus.locked), 0);
        model_clear();
        rst_n = 1'b1;

        // 2: single step then zero error
        cycle(1, 8); cycle(0, 0); cycle(0, 0);
        check("step_code", longint'(bus.ctrl_code), 2057);
        check("step_valid", longint'(bus.ctrl_valid), 1);
        cycle(0, 0);
        check("step_valid_pulse", longint'(bus.ctrl_valid), 0);
        check("step_hold", longint'(bus.ctrl_code), 2057);
        cycle(1, 0); cycle(0, 0); cycle(0, 0);
        check("zero_err_code", longint'(bus.ctrl_code), 2049);

        // 1b: asynchronous reset between edges
        @(posedge clkin);
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_code", longint'(bus.ctrl_code), 2048);
        check("async_rst_valid", longint'(bus.ctrl_valid), 0);
        repeat (2) @(posedge clkin);
        #1 rst_n = 1'b1;

        // 3: positive saturation, anti-windup, recovery
        repeat (40) cycle(1, 511);
        repeat (2) cycle(0, 0);
        check("sat_hi_code", longint'(bus.ctrl_code), 4095);
        check("sat_hi_flag", longint'(bus.sat_hi), 1);
        cycle(1, -511); cycle(1, -511); cycle(0, 0);
        check("recover_below_max", (bus.ctrl_code < 12'd4095) ? 1 : 0, 1);
        repeat (6) cycle(1, -511);

        // 4: negative clamp with full-scale negative error
        repeat (80) cycle(1, -512);
        repeat (2) cycle(0, 0);
        check("sat_lo_code", longint'(bus.ctrl_code), 0);
        check("sat_lo_flag", longint'(bus.sat_lo), 1);
        check("sat_lo_hi_clear", longint'(bus.sat_hi), 0);

        // 5: lock acquisition, hysteresis, loss
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            cycle(1, lock_seq[i]); cycle(0, 0);
            check($sformatf("lock_run_%0d", i), longint'(bus.locked), (i == 7) ? 1 : 0);
        end
        cycle(1, 6); cycle(0, 0);
        check("lock_hyst_6", longint'(bus.locked), 1);
        cycle(1, -8); cycle(0, 0);
        check("lock_hyst_edge_8", longint'(bus.locked), 1);
        cycle(1, 9); cycle(0, 0);
        check("unlock_9", longint'(bus.locked), 0);
        repeat (8) cycle(1, -4);
        cycle(0, 0);
        check("relock", longint'(bus.locked), 1);
        cycle(1, -512); cycle(0, 0);
        check("unlock_neg_full", longint'(bus.locked), 0);
        for (int i = 0; i < 15; i++) begin
            cycle(1, (i == 7) ? 5 : 3); cycle(0, 0);
            check($sformatf("broken_run_%0d", i), longint'(bus.locked), 0);
        end
        cycle(1, 3); cycle(0, 0);
        check("lock_after_break", longint'(bus.locked), 1);

        // 6: sparse valid, then reset with a sample in flight
        apply_reset(2);
        for (int k = 0; k < 6; k++) begin
            cycle(1, sparse[k]); cycle(0, 0); cycle(0, 0);
        end
        cycle(1, 100);
        @(posedge clkin);
        #1 rst_n = 1'b0;
        model_clear();
        bus.err_valid = 1'b0;
        @(posedge clkin);
        #1 rst_n = 1'b1;
        repeat (4) cycle(0, 0);
        check("midpipe_rst_code", longint'(bus.ctrl_code), 2048);

        repeat (3) cycle(0, 0);
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
